game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level game flow controller for a lane-runner style video game.  It walks
// through a start-up countdown, scrolls a logo layer in, slides the player
// sprite down into view, then runs the game loop (lane changes, coin score,
// frame counter) until a collision ends the game.  All animation advances only
// on the once-per-frame tick; coins and collisions act on the next clock.
//
// Ports
//   i_clk           system clock
//   i_rst           asynchronous active-high reset
//   i_frame_tick    single-cycle pulse, one per video frame
//   i_btn_left      synchronised left button level
//   i_btn_right     synchronised right button level
//   i_coin_hit      single-cycle pulse, coin collected
//   i_collide       single-cycle pulse, obstacle collision
//   i_restart       single-cycle pulse, synchronous restart to reset values
//   o_state         0=COUNT 1=LOGO 2=INTRO 3=PLAY 4=OVER
//   o_logo_voffset  logo layer vertical offset
//   o_head_voffset  player vertical offset
//   o_head_hoffset  player horizontal offset (two's complement)
//   o_lane          current lane index
//   o_score         collected-coin count (saturating)
//   o_frame_count   frames elapsed in PLAY (wrapping)
//   o_play_active   high while in PLAY
//   o_game_over     high while in OVER
//
// LANES must lie in 2..8 so that the lane index fits the 3-bit o_lane port.
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int WIDTH      = 12,
    parameter int LANES      = 3,
    parameter int LANE_STEP  = 100,
    parameter int COUNTDOWN  = 5,
    parameter int LOGO_STEP  = 30,
    parameter int LOGO_END   = 640,
    parameter int HEAD_START = 180,
    parameter int HEAD_END   = 50,
    parameter int HEAD_STEP  = 20,
    parameter int SCORE_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_tick,
    input  logic               i_btn_left,
    input  logic               i_btn_right,
    input  logic               i_coin_hit,
    input  logic               i_collide,
    input  logic               i_restart,
    output logic [2:0]         o_state,
    output logic [WIDTH-1:0]   o_logo_voffset,
    output logic [WIDTH-1:0]   o_head_voffset,
    output logic [WIDTH-1:0]   o_head_hoffset,
    output logic [2:0]         o_lane,
    output logic [SCORE_W-1:0] o_score,
    output logic [WIDTH-1:0]   o_frame_count,
    output logic               o_play_active,
    output logic               o_game_over
);

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_LOGO  = 3'd1,
        S_INTRO = 3'd2,
        S_PLAY  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Countdown register is sized to hold COUNTDOWN itself.
    localparam int          CW          = $clog2(COUNTDOWN + 2);
    localparam int          LANE_CENTER = (LANES - 1) / 2;
    localparam logic [2:0]  LANE_RESET  = 3'(LANE_CENTER);
    localparam logic [2:0]  LANE_MAX    = 3'(LANES - 1);

    state_t               r_state;
    logic [CW-1:0]        r_counter;
    logic [WIDTH-1:0]     r_logo_voffset;
    logic [WIDTH-1:0]     r_head_voffset;
    logic [WIDTH-1:0]     r_head_hoffset;
    logic [2:0]           r_lane;
    logic [SCORE_W-1:0]   r_score;
    logic [WIDTH-1:0]     r_frame_count;
    logic                 r_play_active;
    logic                 r_game_over;
    logic                 r_pend_left;
    logic                 r_pend_right;
    logic                 r_btn_left_q;
    logic                 r_btn_right_q;

    logic                 w_edge_left;
    logic                 w_edge_right;
    logic                 w_req_left;
    logic                 w_req_right;
    logic                 w_soft_reset;
    logic signed [31:0]   w_lane_signed;
    logic [WIDTH-1:0]     w_head_hoffset;

    // A press counts once: only the low-to-high transition of the level.
    assign w_edge_left  = i_btn_left  & ~r_btn_left_q;
    assign w_edge_right = i_btn_right & ~r_btn_right_q;

    // A press arriving in the same cycle as the tick is still honoured.
    assign w_req_left   = r_pend_left  | w_edge_left;
    assign w_req_right  = r_pend_right | w_edge_right;

    // Restart and any corrupted state encoding both fall back to reset values.
    assign w_soft_reset = i_restart | (r_state > S_OVER);

    // Horizontal offset is the signed lane distance from the centre lane,
    // scaled by the lane pitch and wrapped to the output width.
    assign w_lane_signed  = signed'({29'd0, r_lane});
    assign w_head_hoffset = WIDTH'((w_lane_signed - LANE_CENTER) * LANE_STEP);

    // Button history keeps tracking the pad even across restarts so that a
    // button held through a restart does not fire a spurious request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btn_left_q  <= 1'b0;
            r_btn_right_q <= 1'b0;
        end else begin
            r_btn_left_q  <= i_btn_left;
            r_btn_right_q <= i_btn_right;
        end
    end

    // Game flow state machine together with all animation and score state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_COUNT;
            r_counter      <= CW'(COUNTDOWN);
            r_logo_voffset <= '0;
            r_head_voffset <= WIDTH'(HEAD_START);
            r_head_hoffset <= '0;
            r_lane         <= LANE_RESET;
            r_score        <= '0;
            r_frame_count  <= '0;
            r_play_active  <= 1'b0;
            r_game_over    <= 1'b0;
            r_pend_left    <= 1'b0;
            r_pend_right   <= 1'b0;
        end else if (w_soft_reset) begin
            r_state        <= S_COUNT;
            r_counter      <= CW'(COUNTDOWN);
            r_logo_voffset <= '0;
            r_head_voffset <= WIDTH'(HEAD_START);
            r_head_hoffset <= '0;
            r_lane         <= LANE_RESET;
            r_score        <= '0;
            r_frame_count  <= '0;
            r_play_active  <= 1'b0;
            r_game_over    <= 1'b0;
            r_pend_left    <= 1'b0;
            r_pend_right   <= 1'b0;
        end else begin
            // Offset follows the lane one clock later.
            r_head_hoffset <= w_head_hoffset;

            // Pending requests live until the next frame tick; OVER drops them.
            if ((r_state == S_OVER) || i_frame_tick) begin
                r_pend_left  <= 1'b0;
                r_pend_right <= 1'b0;
            end else begin
                r_pend_left  <= w_req_left;
                r_pend_right <= w_req_right;
            end

            case (r_state)
                S_COUNT: begin
                    if (i_frame_tick) begin
                        if (r_counter != '0) begin
                            r_counter <= r_counter - CW'(1);
                        end else begin
                            r_state <= S_LOGO;
                        end
                    end
                end

                S_LOGO: begin
                    if (i_frame_tick) begin
                        if (r_logo_voffset < WIDTH'(LOGO_END)) begin
                            r_logo_voffset <= r_logo_voffset + WIDTH'(LOGO_STEP);
                        end else begin
                            r_state <= S_INTRO;
                        end
                    end
                end

                S_INTRO: begin
                    if (i_frame_tick) begin
                        if (r_head_voffset > WIDTH'(HEAD_END)) begin
                            r_head_voffset <= r_head_voffset - WIDTH'(HEAD_STEP);
                        end else begin
                            r_state       <= S_PLAY;
                            r_play_active <= 1'b1;
                        end
                    end
                end

                S_PLAY: begin
                    if (i_frame_tick) begin
                        r_frame_count <= r_frame_count + WIDTH'(1);
                        // Opposing requests in one frame cancel; edges clamp.
                        if (w_req_left && !w_req_right && (r_lane != 3'd0)) begin
                            r_lane <= r_lane - 3'd1;
                        end else if (w_req_right && !w_req_left && (r_lane < LANE_MAX)) begin
                            r_lane <= r_lane + 3'd1;
                        end
                    end
                    if (i_coin_hit && (r_score != {SCORE_W{1'b1}})) begin
                        r_score <= r_score + SCORE_W'(1);
                    end
                    if (i_collide) begin
                        r_state       <= S_OVER;
                        r_play_active <= 1'b0;
                        r_game_over   <= 1'b1;
                    end
                end

                S_OVER: begin
                    r_state <= S_OVER;
                end

                default: begin
                    r_state <= S_COUNT;
                end
            endcase
        end
    end

    assign o_state        = r_state;
    assign o_logo_voffset = r_logo_voffset;
    assign o_head_voffset = r_head_voffset;
    assign o_head_hoffset = r_head_hoffset;
    assign o_lane         = r_lane;
    assign o_score        = r_score;
    assign o_frame_count  = r_frame_count;
    assign o_play_active  = r_play_active;
    assign o_game_over    = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Self-checking bench for game_sequencer.  Two instances share the stimulus:
// one with default parameters and one with a 4-bit score so saturation can be
// reached quickly.  A behavioural model of the game rules tracks both and is
// compared every clock; a table of frame-level vectors and a few hand-written
// sequences check the documented milestones against fixed values.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    localparam int WIDTH      = 12;
    localparam int LANES      = 3;
    localparam int LANE_STEP  = 100;
    localparam int COUNTDOWN  = 5;
    localparam int LOGO_STEP  = 30;
    localparam int LOGO_END   = 640;
    localparam int HEAD_START = 180;
    localparam int HEAD_END   = 50;
    localparam int HEAD_STEP  = 20;
    localparam int CENTER     = (LANES - 1) / 2;
    localparam int WMASK      = (1 << WIDTH) - 1;

    logic        clk;
    logic        rst;
    logic        frameTick;
    logic        btnLeft;
    logic        btnRight;
    logic        coinHit;
    logic        collide;
    logic        restart;

    logic [2:0]  state,      state4;
    logic [11:0] logoV,      logoV4;
    logic [11:0] headV,      headV4;
    logic [11:0] headH,      headH4;
    logic [2:0]  lane,       lane4;
    logic [15:0] score;
    logic [3:0]  score4;
    logic [11:0] frameCount, frameCount4;
    logic        playActive, playActive4;
    logic        gameOver,   gameOver4;

    logic [71:0] dutVec;
    logic [71:0] dut4Vec;

    int nChecks;
    int nErrors;

    // behavioural model of the game rules
    int mState, mCnt, mLogo, mHeadv, mLane, mHoff, mScore, mScore4, mFrame;
    bit mPrevL, mPrevR, mPendL, mPendR;

    typedef struct {
        int frames;
        int l, r, coin, col, rs;
        int eState, eLogo, eHeadv, eLane, eHoff, eScore;
    } vec_t;

    vec_t vecs[20];

    game_sequencer u_dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(frameTick),
        .i_btn_left(btnLeft), .i_btn_right(btnRight),
        .i_coin_hit(coinHit), .i_collide(collide), .i_restart(restart),
        .o_state(state), .o_logo_voffset(logoV), .o_head_voffset(headV),
        .o_head_hoffset(headH), .o_lane(lane), .o_score(score),
        .o_frame_count(frameCount), .o_play_active(playActive), .o_game_over(gameOver)
    );

    game_sequencer #(.SCORE_W(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(frameTick),
        .i_btn_left(btnLeft), .i_btn_right(btnRight),
        .i_coin_hit(coinHit), .i_collide(collide), .i_restart(restart),
        .o_state(state4), .o_logo_voffset(logoV4), .o_head_voffset(headV4),
        .o_head_hoffset(headH4), .o_lane(lane4), .o_score(score4),
        .o_frame_count(frameCount4), .o_play_active(playActive4), .o_game_over(gameOver4)
    );

    assign dutVec  = {state, logoV, headV, headH, lane, score, frameCount, playActive, gameOver};
    assign dut4Vec = {state4, logoV4, headV4, headH4, lane4, {12'd0, score4}, frameCount4,
                      playActive4, gameOver4};

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [71:0] packVec(input int st, input int logo, input int headv,
                                            input int hoff, input int ln, input int sc,
                                            input int frame);
        return {3'(st), 12'(logo), 12'(headv), 12'(hoff), 3'(ln), 16'(sc), 12'(frame),
                (st == 3), (st == 4)};
    endfunction

    function automatic int hoffOf(input int ln);
        return ((ln - CENTER) * LANE_STEP) & WMASK;
    endfunction

    // Values every game quantity takes after a reset or restart.
    task automatic modelGameReset();
        mState  = 0;
        mCnt    = COUNTDOWN;
        mLogo   = 0;
        mHeadv  = HEAD_START;
        mLane   = CENTER;
        mHoff   = 0;
        mScore  = 0;
        mScore4 = 0;
        mFrame  = 0;
        mPendL  = 0;
        mPendR  = 0;
    endtask

    task automatic modelReset();
        modelGameReset();
        mPrevL = 0;
        mPrevR = 0;
    endtask

    // Advance the model by one clock given the inputs sampled at that edge.
    task automatic modelStep(input logic tick, input logic l, input logic r,
                             input logic coin, input logic col, input logic rs);
        bit eL, eR, reqL, reqR;
        int stBefore;
        eL = l && !mPrevL;
        eR = r && !mPrevR;
        reqL = mPendL || eL;
        reqR = mPendR || eR;
        mPrevL = l;
        mPrevR = r;
        stBefore = mState;
        if (rs) begin
            modelGameReset();
            return;
        end
        mHoff = hoffOf(mLane);
        if (stBefore == 4 || tick) begin
            mPendL = 0;
            mPendR = 0;
        end else begin
            mPendL = reqL;
            mPendR = reqR;
        end
        case (stBefore)
            0: if (tick) begin
                if (mCnt > 0) mCnt = mCnt - 1;
                else mState = 1;
            end
            1: if (tick) begin
                if (mLogo < LOGO_END) mLogo = mLogo + LOGO_STEP;
                else mState = 2;
            end
            2: if (tick) begin
                if (mHeadv > HEAD_END) mHeadv = mHeadv - HEAD_STEP;
                else mState = 3;
            end
            3: begin
                if (tick) begin
                    mFrame = (mFrame + 1) & WMASK;
                    if (reqL && !reqR && mLane > 0) mLane = mLane - 1;
                    else if (reqR && !reqL && mLane < LANES - 1) mLane = mLane + 1;
                end
                if (coin) begin
                    if (mScore < 65535) mScore = mScore + 1;
                    if (mScore4 < 15) mScore4 = mScore4 + 1;
                end
                if (col) mState = 4;
            end
            default: ;
        endcase
    endtask

    task automatic checkVec(input string name, input logic [71:0] act, input logic [71:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        checkVec(name, dutVec,
                 packVec(mState, mLogo, mHeadv, mHoff, mLane, mScore, mFrame));
        checkVec({name, "4"}, dut4Vec,
                 packVec(mState, mLogo, mHeadv, mHoff, mLane, mScore4, mFrame));
    endtask

    task automatic checkResetState(input string name);
        checkVec(name, dutVec, packVec(0, 0, HEAD_START, 0, CENTER, 0, 0));
        checkVec({name, "4"}, dut4Vec, packVec(0, 0, HEAD_START, 0, CENTER, 0, 0));
    endtask

    // Drive one clock of inputs, step the model, then compare after the edge.
    task automatic applyStimulus(input logic tick, input logic l, input logic r,
                                 input logic coin, input logic col, input logic rs);
        frameTick = tick;
        btnLeft   = l;
        btnRight  = r;
        coinHit   = coin;
        collide   = col;
        restart   = rs;
        modelStep(tick, l, r, coin, col, rs);
        @(posedge clk);
        #1;
        checkOutput("model");
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic bL, bR, t, cn, cl, rs;
        nChecks = 0;
        nErrors = 0;

        // frames, L, R, coin, col, restart | state, logo, headv, lane, hoff, score
        vecs[0]  = '{5,  0, 0, 0, 0, 0,  0,   0, 180, 1,    0, 0};
        vecs[1]  = '{1,  0, 0, 0, 0, 0,  1,   0, 180, 1,    0, 0};
        vecs[2]  = '{21, 0, 0, 0, 0, 0,  1, 630, 180, 1,    0, 0};
        vecs[3]  = '{1,  0, 0, 0, 0, 0,  1, 660, 180, 1,    0, 0};
        vecs[4]  = '{1,  0, 0, 0, 0, 0,  2, 660, 180, 1,    0, 0};
        vecs[5]  = '{7,  0, 0, 0, 0, 0,  2, 660,  40, 1,    0, 0};
        vecs[6]  = '{1,  0, 0, 0, 0, 0,  3, 660,  40, 1,    0, 0};
        vecs[7]  = '{1,  0, 1, 0, 0, 0,  3, 660,  40, 2,  100, 0};
        vecs[8]  = '{1,  0, 0, 0, 0, 0,  3, 660,  40, 2,  100, 0};
        vecs[9]  = '{1,  0, 1, 0, 0, 0,  3, 660,  40, 2,  100, 0};
        vecs[10] = '{1,  1, 0, 0, 0, 0,  3, 660,  40, 1,    0, 0};
        vecs[11] = '{1,  0, 0, 0, 0, 0,  3, 660,  40, 1,    0, 0};
        vecs[12] = '{1,  1, 0, 0, 0, 0,  3, 660,  40, 0, 3996, 0};
        vecs[13] = '{1,  0, 0, 0, 0, 0,  3, 660,  40, 0, 3996, 0};
        vecs[14] = '{1,  1, 0, 0, 0, 0,  3, 660,  40, 0, 3996, 0};
        vecs[15] = '{10, 0, 1, 0, 0, 0,  3, 660,  40, 1,    0, 0};
        vecs[16] = '{3,  0, 0, 1, 0, 0,  3, 660,  40, 1,    0, 3};
        vecs[17] = '{1,  0, 0, 1, 1, 0,  4, 660,  40, 1,    0, 4};
        vecs[18] = '{3,  1, 0, 1, 0, 0,  4, 660,  40, 1,    0, 4};
        vecs[19] = '{1,  0, 0, 0, 0, 1,  0,   0, 180, 1,    0, 0};

        // Power-on reset
        rst = 1'b1;
        frameTick = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
        coinHit = 1'b0; collide = 1'b0; restart = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkResetState("resetValues");
        rst = 1'b0;

        // Frame-level vector table: pulses on the first clock, tick on the
        // second, result checked after a settling clock.
        for (int v = 0; v < 20; v++) begin
            for (int f = 0; f < vecs[v].frames; f++) begin
                applyStimulus(1'b0, vecs[v].l != 0, vecs[v].r != 0, vecs[v].coin != 0,
                              vecs[v].col != 0, vecs[v].rs != 0);
                applyStimulus(1'b1, vecs[v].l != 0, vecs[v].r != 0, 1'b0, 1'b0, 1'b0);
                applyStimulus(1'b0, vecs[v].l != 0, vecs[v].r != 0, 1'b0, 1'b0, 1'b0);
            end
            checkVec($sformatf("vec%0d", v),
                     {10'd0, state, logoV, headV, lane, headH, score, score4},
                     {10'd0, 3'(vecs[v].eState), 12'(vecs[v].eLogo), 12'(vecs[v].eHeadv),
                      3'(vecs[v].eLane), 12'(vecs[v].eHoff), 16'(vecs[v].eScore),
                      4'(vecs[v].eScore)});
        end

        // Coin outside PLAY is ignored.
        runTicks(5);
        checkInt("enterLogo", int'(state), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkInt("coinInLogo", int'(score), 0);
        runTicks(31);
        checkInt("enterPlay", int'(state), 3);

        // Left and right edges in the same frame cancel and are not carried.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkInt("bothEdgesLane", int'(lane), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkInt("bothEdgesCleared", int'(lane), 1);

        // Score saturation on the 4-bit instance.
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkInt("score4At14", int'(score4), 14);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkInt($sformatf("score4Sat%0d", k), int'(score4), 15);
            checkInt($sformatf("score16Inc%0d", k), int'(score), 15 + k);
        end

        // Asynchronous reset between clock edges mid-PLAY.
        checkInt("prePlayState", int'(state), 3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkResetState("asyncReset");
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomised run against the model.
        bL = 1'b0;
        bR = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            t  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) bL = ~bL;
            if ($urandom_range(0, 3) == 0) bR = ~bR;
            cn = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 199) == 0);
            applyStimulus(t, bL, bR, cn, cl, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
